sub_bytes_pipe: RTL and testbench

//   Multi-lane AES byte-substitution engine: LANES parallel bytes per beat, each mapped

---
 rtl/sub_bytes_pipe.sv | 228 ++++++++++++++++++++++
 tb/tb_sub_bytes_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_pipe.sv
// sub_bytes_pipe
//   Multi-lane AES byte substitution with an elastic valid/ready pipeline.
//   Each beat carries LANES bytes. Every byte goes through either the forward
//   AES S-box or, when INV_EN = 1 and in_inv is set, the inverse S-box. The
//   mode bit travels with its beat, so encrypt and decrypt beats may be mixed
//   freely. The lookup is combinational and feeds stage 1. Stages 2..N only
//   carry the beat forward. The output comes straight from the last stage
//   register.
//
//   The S-box is computed rather than stored: GF(2^8) inversion followed by
//   the affine map. The inverse applies the inverse affine map, then inverts.
//   The two directions are exact inverses by construction.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  a beat can be accepted this cycle (depends on out_ready)
//   in_inv     in   0 = forward S-box, 1 = inverse S-box (ignored if INV_EN=0)
//   in_data    in   LANES bytes, lane k = in_data[8k+7:8k]
//   out_valid  out  output beat valid
//   out_ready  in   downstream accepts the output beat
//   out_inv    out  mode of the beat on out_data (0 when INV_EN=0)
//   out_data   out  substituted bytes, lane order preserved
//   occupancy  out  beats held in the pipeline, 0..PIPE_STAGES
module sub_bytes_pipe #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned PIPE_STAGES = 1,
  parameter bit          INV_EN      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_inv,
  input  logic [8*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_inv,
  output logic [8*LANES-1:0]   out_data,
  output logic [1:0]           occupancy
);

  localparam int unsigned W       = 8 * LANES;
  localparam logic [1:0]  OCC_MAX = 2'(PIPE_STAGES);

  // ---------------------------------------------------------------------
  // GF(2^8) helpers, AES polynomial x^8 + x^4 + x^3 + x + 1
  // ---------------------------------------------------------------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      else      p = p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse; 0 maps to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
    return 8'((a << n) | (a >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  // ---------------------------------------------------------------------
  // Lookup feeding stage 1
  // ---------------------------------------------------------------------
  logic [W-1:0] lut_s;
  logic         lut_inv_s;

  if (INV_EN) begin : g_lut_both
    // per-lane forward or inverse substitution selected by the beat's mode
    always_comb begin
      lut_s     = '0;
      lut_inv_s = in_inv;
      for (int k = 0; k < int'(LANES); k++) begin
        if (in_inv) lut_s[8*k +: 8] = sbox_inv(in_data[8*k +: 8]);
        else        lut_s[8*k +: 8] = sbox_fwd(in_data[8*k +: 8]);
      end
    end
  end else begin : g_lut_fwd
    // forward-only substitution; the mode input is not used
    always_comb begin
      lut_s     = '0;
      lut_inv_s = 1'b0;
      for (int k = 0; k < int'(LANES); k++) begin
        lut_s[8*k +: 8] = sbox_fwd(in_data[8*k +: 8]);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Elastic pipeline
  // ---------------------------------------------------------------------
  logic [PIPE_STAGES-1:0] v_vec_s;
  logic [PIPE_STAGES-1:0] rdy_s;
  logic                   acc_s;

  // A stage has room when it is empty or when everything downstream moves.
  // Walk back from the output so the stall propagates the full pipe length.
  always_comb begin
    rdy_s = '0;
    acc_s = out_ready;
    for (int i = int'(PIPE_STAGES) - 1; i >= 0; i--) begin
      acc_s    = ~v_vec_s[i] | acc_s;
      rdy_s[i] = acc_s;
    end
  end

  for (genvar g = 0; g < int'(PIPE_STAGES); g++) begin : g_stage
    logic         src_v_s;
    logic         src_inv_s;
    logic [W-1:0] src_d_s;
    logic         v_q,   v_d;
    logic         inv_q, inv_d;
    logic [W-1:0] d_q,   d_d;

    if (g == 0) begin : g_head
      assign src_v_s   = in_valid;
      assign src_d_s   = lut_s;
      assign src_inv_s = lut_inv_s;
    end else begin : g_body
      assign src_v_s   = g_stage[g-1].v_q;
      assign src_d_s   = g_stage[g-1].d_q;
      assign src_inv_s = g_stage[g-1].inv_q;
    end

    assign v_vec_s[g] = v_q;

    // Load the upstream beat when there is room. Payload is only written on
    // a real load, so a draining stage keeps its last data.
    always_comb begin
      v_d   = v_q;
      d_d   = d_q;
      inv_d = inv_q;
      if (rdy_s[g]) begin
        v_d = src_v_s;
        if (src_v_s) begin
          d_d   = src_d_s;
          inv_d = src_inv_s;
        end else begin
          d_d   = d_q;
          inv_d = inv_q;
        end
      end else begin
        v_d = v_q;
      end
    end

    // stage register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        d_q   <= '0;
        inv_q <= 1'b0;
      end else begin
        v_q   <= v_d;
        d_q   <= d_d;
        inv_q <= inv_d;
      end
    end
  end

  assign in_ready  = rdy_s[0];
  assign out_valid = g_stage[PIPE_STAGES-1].v_q;
  assign out_data  = g_stage[PIPE_STAGES-1].d_q;
  assign out_inv   = g_stage[PIPE_STAGES-1].inv_q;

  // ---------------------------------------------------------------------
  // Occupancy counter
  // ---------------------------------------------------------------------
  logic       in_acc_s;
  logic       out_acc_s;
  logic [1:0] occ_q, occ_d;

  assign in_acc_s  = in_valid & rdy_s[0];
  assign out_acc_s = out_valid & out_ready;

  // +1 on accept, -1 on emit, unchanged when both happen together
  always_comb begin
    occ_d = occ_q;
    case ({in_acc_s, out_acc_s})
      2'b10: begin
        if (occ_q == OCC_MAX) occ_d = occ_q;
        else                  occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd0) occ_d = occ_q;
        else               occ_d = occ_q - 2'd1;
      end
      default: occ_d = occ_q;
    endcase
  end

  // occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= 2'd0;
    else        occ_q <= occ_d;
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
module tb_sub_bytes_pipe;

  localparam int PIPE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, in_inv;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_inv;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  logic        d2_in_valid, d2_in_ready, d2_in_inv;
  logic [7:0]  d2_in_data;
  logic        d2_out_valid, d2_out_ready, d2_out_inv;
  logic [7:0]  d2_out_data;
  logic [1:0]  d2_occupancy;

  sub_bytes_pipe #(.LANES(4), .PIPE_STAGES(PIPE), .INV_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv), .out_data(out_data),
    .occupancy(occupancy)
  );

  sub_bytes_pipe #(.LANES(1), .PIPE_STAGES(1), .INV_EN(1'b0)) dut_fwd (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_inv(d2_in_inv), .in_data(d2_in_data),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_inv(d2_out_inv), .out_data(d2_out_data),
    .occupancy(d2_occupancy)
  );

  // FIPS-197 forward S-box
  logic [7:0] sbox_t [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  logic [7:0] isbox_t [256];

  typedef struct packed { logic [31:0] d; logic inv; logic [31:0] exp; } tx_t;
  typedef struct packed { logic [31:0] exp; logic inv; logic [31:0] cyc; } sb_t;

  tx_t         tx_q[$];
  sb_t         sb_q[$];
  logic [31:0] col_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pops = 0;
  int          first_pop = -1;
  int          last_pop = -1;
  bit          lat_chk = 1'b0;
  bit          collect = 1'b0;
  bit          rand_rdy = 1'b0;
  logic [31:0] hold_d;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic inv);
    logic [31:0] r;
    r = 32'h0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = inv ? isbox_t[d[8*k +: 8]] : sbox_t[d[8*k +: 8]];
    return r;
  endfunction

  // every lane walks all 256 byte values as j goes 0..255
  function automatic logic [31:0] pat(input int j);
    logic [7:0] b;
    b = 8'(j);
    return {8'(j * 7 + 1), b ^ 8'hA5, 8'hFF - b, b};
  endfunction

  task automatic send(input logic [31:0] d, input logic inv, input logic [31:0] exp);
    tx_t t;
    t.d = d; t.inv = inv; t.exp = exp;
    tx_q.push_back(t);
  endtask

  task automatic send_m(input logic [31:0] d, input logic inv);
    send(d, inv, model(d, inv));
  endtask

  // one clock: drive at negedge, account handshakes before the posedge
  task automatic cycle();
    tx_t t;
    sb_t e;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    if (tx_q.size() > 0) begin
      in_valid = 1'b1; in_data = tx_q[0].d; in_inv = tx_q[0].inv;
    end else begin
      in_valid = 1'b0; in_data = 32'h0; in_inv = 1'b0;
    end
    #1;
    check_eq("occupancy", 64'(occupancy), 64'(sb_q.size()));
    if (in_valid && in_ready) begin
      t = tx_q.pop_front();
      e.exp = t.exp; e.inv = t.inv; e.cyc = 32'(cyc);
      sb_q.push_back(e);
    end
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("out_data", 64'(out_data), 64'(e.exp));
        check_eq("out_inv", 64'(out_inv), 64'(e.inv));
        if (lat_chk) check_eq("latency", 64'(32'(cyc) - e.cyc), 64'(PIPE));
        if (collect) col_q.push_back(out_data);
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        pops++;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((tx_q.size() != 0 || sb_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) check_eq("drain_timeout", 64'(tx_q.size() + sb_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
    rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    d2_in_valid = 1'b0; d2_in_inv = 1'b0; d2_in_data = 8'h00; d2_out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_inv", 64'(out_inv), 64'd0);
    check_eq("rst_occupancy", 64'(occupancy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // T1 / T2: known vectors with latency check
    out_ready = 1'b1;
    lat_chk = 1'b1;
    send(32'hFF53_0100, 1'b0, 32'h16ED_7C63);
    drain(20);
    send(32'h16ED_7C63, 1'b1, 32'hFF53_0100);
    send(32'h0000_0000, 1'b1, 32'h5252_5252);
    drain(20);
    lat_chk = 1'b0;

    // T3: every byte on every lane, alternating mode, random backpressure
    rand_rdy = 1'b1;
    for (int j = 0; j < 256; j++) send_m(pat(j), 1'((j & 1)));
    drain(3000);
    rand_rdy = 1'b0;
    out_ready = 1'b1;

    // T3 round trip: forward outputs fed back through the inverse
    col_q.delete();
    collect = 1'b1;
    for (int j = 0; j < 256; j++) send_m(pat(j), 1'b0);
    drain(1000);
    collect = 1'b0;
    check_eq("rt_count", 64'(col_q.size()), 64'd256);
    for (int j = 0; j < col_q.size(); j++) send(col_q[j], 1'b1, pat(j));
    drain(1000);

    // T4: backpressure fills the pipe, then drains without gaps
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) send_m(pat(40 + j), 1'((j & 1)));
    repeat (4) cycle();
    #1;
    check_eq("bp_in_ready", 64'(in_ready), 64'd0);
    check_eq("bp_occupancy", 64'(occupancy), 64'd2);
    check_eq("bp_pending", 64'(tx_q.size()), 64'd3);
    hold_d = out_data;
    repeat (2) cycle();
    #1;
    check_eq("bp_hold_data", 64'(out_data), 64'(hold_d));
    check_eq("bp_hold_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    pops = 0; first_pop = -1; last_pop = -1;
    drain(50);
    check_eq("bp_pops", 64'(pops), 64'd5);
    check_eq("bp_no_gaps", 64'(last_pop - first_pop), 64'd4);

    // T5: asynchronous reset with the pipe full
    out_ready = 1'b0;
    send_m(pat(77), 1'b0);
    send_m(pat(78), 1'b1);
    repeat (3) cycle();
    #1;
    check_eq("mr_occ_before", 64'(occupancy), 64'd2);
    rst_n = 1'b0;
    #1;
    check_eq("mr_out_valid", 64'(out_valid), 64'd0);
    check_eq("mr_occupancy", 64'(occupancy), 64'd0);
    tx_q.delete();
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    lat_chk = 1'b1;
    send_m(pat(99), 1'b1);
    drain(20);
    lat_chk = 1'b0;

    // T6: forward-only instance ignores the mode bit
    d2_in_valid = 1'b1; d2_in_inv = 1'b1; d2_in_data = 8'h00;
    cycle();
    d2_in_data = 8'h53;
    #1;
    check_eq("fo_valid", 64'(d2_out_valid), 64'd1);
    check_eq("fo_data0", 64'(d2_out_data), 64'h63);
    check_eq("fo_inv0", 64'(d2_out_inv), 64'd0);
    @(negedge clk);
    d2_in_valid = 1'b0;
    #1;
    check_eq("fo_data1", 64'(d2_out_data), 64'hED);
    check_eq("fo_inv1", 64'(d2_out_inv), 64'd0);
    @(negedge clk);
    #1;
    check_eq("fo_drained", 64'(d2_out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
